// File: rtl/game_round_ctrl.sv
// Round sequencer for the zombie-hit game: IDLE -> READY countdown -> PLAY -> OVER.
// Owns score, lives, countdown timer and the 1 s tick; drives game_logic's end_flag and restart.
module game_round_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int READY_SECS = 3,
    parameter int GAME_SECS  = 30,
    parameter int LIVES      = 3,
    parameter int SCORE_MAX  = 99
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       hit,
    input  logic       fail,
    output logic       end_flag,
    output logic       gl_reset,
    output logic [1:0] state,
    output logic [6:0] time_left,
    output logic [6:0] score,
    output logic [2:0] lives,
    output logic       tick
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READY = 2'b01,
        ST_PLAY  = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam logic [31:0] TICK_LAST   = 32'(TICK_DIV - 1);
    localparam logic [6:0]  READY_INIT  = 7'(READY_SECS);
    localparam logic [6:0]  GAME_INIT   = 7'(GAME_SECS);
    localparam logic [2:0]  LIVES_INIT  = 3'(LIVES);
    localparam logic [6:0]  SCORE_LIMIT = 7'(SCORE_MAX);

    state_t      state_q,  state_d;
    logic [6:0]  time_q,   time_d;
    logic [6:0]  score_q,  score_d;
    logic [2:0]  lives_q,  lives_d;
    logic [31:0] presc_q,  presc_d;
    logic        tick_q,   tick_d;
    logic        end_q,    end_d;
    logic        glr_q,    glr_d;
    logic        start_q;
    logic        fail_q;

    logic        start_edge_s;
    logic        fail_edge_s;
    logic        run_s;
    logic        tick_s;

    // Next-state logic for the round sequencer and its counters.
    always_comb begin
        start_edge_s = start_q & ~start_btn;
        fail_edge_s  = ~fail_q & fail;
        run_s        = (state_q == ST_READY) || (state_q == ST_PLAY);
        tick_s       = run_s && (presc_q == TICK_LAST);

        state_d = state_q;
        time_d  = time_q;
        score_d = score_q;
        lives_d = lives_q;
        glr_d   = 1'b1;
        tick_d  = tick_s;
        if (!run_s || tick_s) begin
            presc_d = 32'd0;
        end else begin
            presc_d = presc_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_d = ST_READY;
                    time_d  = READY_INIT;
                    score_d = 7'd0;
                    lives_d = LIVES_INIT;
                    glr_d   = 1'b0;
                    presc_d = 32'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READY: begin
                if (tick_s && (time_q == 7'd1)) begin
                    state_d = ST_PLAY;
                    time_d  = GAME_INIT;
                    presc_d = 32'd0;
                end else if (tick_s) begin
                    time_d  = time_q - 7'd1;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_PLAY: begin
                if (hit && (score_q < SCORE_LIMIT)) begin
                    score_d = score_q + 7'd1;
                end else begin
                    score_d = score_q;
                end
                if (fail_edge_s && (lives_q != 3'd0)) begin
                    lives_d = lives_q - 3'd1;
                end else begin
                    lives_d = lives_q;
                end
                if (tick_s && (time_q != 7'd0)) begin
                    time_d = time_q - 7'd1;
                end else begin
                    time_d = time_q;
                end
                // Running out of time or lives ends the round on this same edge.
                if ((tick_s && (time_q == 7'd1)) || (fail_edge_s && (lives_q == 3'd1))) begin
                    state_d = ST_OVER;
                    presc_d = 32'd0;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (start_edge_s) begin
                    state_d = ST_IDLE;
                    time_d  = GAME_INIT;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
                time_d  = GAME_INIT;
            end
        endcase

        end_d = (state_d != ST_PLAY);
    end

    // State, counters, edge detectors and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            time_q  <= GAME_INIT;
            score_q <= 7'd0;
            lives_q <= LIVES_INIT;
            presc_q <= 32'd0;
            tick_q  <= 1'b0;
            end_q   <= 1'b1;
            glr_q   <= 1'b1;
            start_q <= 1'b1;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            score_q <= score_d;
            lives_q <= lives_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            end_q   <= end_d;
            glr_q   <= glr_d;
            start_q <= start_btn;
            fail_q  <= fail;
        end
    end

    assign state     = state_q;
    assign time_left = time_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign tick      = tick_q;
    assign end_flag  = end_q;
    assign gl_reset  = glr_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: two instances with short tick periods,
// expected values hand-computed from the round flow.
module tb_game_round_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: TICK_DIV=10, READY 3, GAME 30, LIVES 3, SCORE_MAX 5
    logic       reset_a, start_a, hit_a, fail_a;
    logic       end_a, glr_a, tick_a;
    logic [1:0] state_a;
    logic [6:0] time_a, score_a;
    logic [2:0] lives_a;

    // Instance B: TICK_DIV=4, READY 3, GAME 2, LIVES 3, SCORE_MAX 99
    logic       reset_b, start_b, hit_b, fail_b;
    logic       end_b, glr_b, tick_b;
    logic [1:0] state_b;
    logic [6:0] time_b, score_b;
    logic [2:0] lives_b;

    int total = 0;
    int bad   = 0;

    game_round_ctrl #(.TICK_DIV(10), .READY_SECS(3), .GAME_SECS(30), .LIVES(3), .SCORE_MAX(5)) dut_a (
        .clock(clock), .reset(reset_a), .start_btn(start_a), .hit(hit_a), .fail(fail_a),
        .end_flag(end_a), .gl_reset(glr_a), .state(state_a), .time_left(time_a),
        .score(score_a), .lives(lives_a), .tick(tick_a)
    );

    game_round_ctrl #(.TICK_DIV(4), .READY_SECS(3), .GAME_SECS(2), .LIVES(3), .SCORE_MAX(99)) dut_b (
        .clock(clock), .reset(reset_b), .start_btn(start_b), .hit(hit_b), .fail(fail_b),
        .end_flag(end_b), .gl_reset(glr_b), .state(state_b), .time_left(time_b),
        .score(score_b), .lives(lives_b), .tick(tick_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset_a = 1'b0; start_a = 1'b1; hit_a = 1'b0; fail_a = 1'b0;
        reset_b = 1'b0; start_b = 1'b1; hit_b = 1'b0; fail_b = 1'b0;

        // Reset then idle
        step(3);
        reset_a = 1'b1;
        step(100);
        chk("idle_state", state_a, 0);
        chk("idle_end",   end_a,   1);
        chk("idle_glr",   glr_a,   1);
        chk("idle_time",  time_a,  30);
        chk("idle_lives", lives_a, 3);
        chk("idle_score", score_a, 0);
        chk("idle_tick",  tick_a,  0);

        // Round start: READY on the edge that sees the press
        start_a = 1'b0;
        step(1);
        chk("start_state", state_a, 1);
        chk("start_glr",   glr_a,   0);
        chk("start_time",  time_a,  3);
        chk("start_end",   end_a,   1);
        step(1);
        chk("glr_one_cycle", glr_a, 1);
        chk("held_no_restart", state_a, 1);
        start_a = 1'b1;
        hit_a = 1'b1;
        step(1);
        hit_a = 1'b0;
        step(8);
        chk("ready_t2",      time_a,  2);
        chk("ready_tick",    tick_a,  1);
        chk("ready_nohit",   score_a, 0);
        step(20);
        chk("play_state", state_a, 2);
        chk("play_time",  time_a,  30);
        chk("play_end",   end_a,   0);

        // Scoring with saturation at 5
        for (int i = 0; i < 7; i++) begin
            hit_a = 1'b1;
            step(1);
            hit_a = 1'b0;
            step(1);
        end
        chk("score_sat", score_a, 5);

        // Held wrong button costs one life
        fail_a = 1'b1;
        step(50);
        fail_a = 1'b0;
        step(1);
        chk("fail_held", lives_a, 2);
        fail_a = 1'b1;
        step(1);
        fail_a = 1'b0;
        chk("fail_pulse2", lives_a, 1);
        chk("still_play",  state_a, 2);
        step(1);
        fail_a = 1'b1;
        hit_a  = 1'b1;
        step(1);
        fail_a = 1'b0;
        hit_a  = 1'b0;
        chk("over_lives", lives_a, 0);
        chk("over_state", state_a, 3);
        chk("over_end",   end_a,   1);
        chk("over_score", score_a, 5);
        chk("over_time",  time_a,  24);

        // OVER freezes everything
        hit_a = 1'b1;
        step(1);
        hit_a = 1'b0;
        step(20);
        chk("frozen_score", score_a, 5);
        chk("frozen_time",  time_a,  24);
        chk("frozen_state", state_a, 3);

        // Back to IDLE, score retained
        start_a = 1'b0;
        step(1);
        chk("to_idle_state", state_a, 0);
        chk("to_idle_time",  time_a,  30);
        chk("to_idle_score", score_a, 5);
        chk("to_idle_glr",   glr_a,   1);
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        step(1);
        chk("r2_state", state_a, 1);
        chk("r2_score", score_a, 0);
        chk("r2_lives", lives_a, 3);
        start_a = 1'b1;
        step(30);
        chk("r2_play", state_a, 2);

        // Start press ignored in PLAY
        start_a = 1'b0;
        step(3);
        chk("play_ignore_start", state_a, 2);
        chk("play_no_glr",       glr_a,   1);
        start_a = 1'b1;
        step(1);

        // Async reset between edges
        #2;
        reset_a = 1'b0;
        #1;
        chk("async_state", state_a, 0);
        chk("async_time",  time_a,  30);
        chk("async_end",   end_a,   1);
        chk("async_lives", lives_a, 3);
        chk("async_score", score_a, 0);
        reset_a = 1'b1;
        step(2);
        chk("post_reset_state", state_a, 0);

        // Timeout on instance B, hit in the final cycle still scores
        reset_b = 1'b1;
        step(2);
        start_b = 1'b0;
        step(1);
        start_b = 1'b1;
        chk("b_ready", state_b, 1);
        step(12);
        chk("b_play_state", state_b, 2);
        chk("b_play_time",  time_b,  2);
        step(4);
        chk("b_time1", time_b,  1);
        chk("b_still", state_b, 2);
        step(3);
        hit_b = 1'b1;
        step(1);
        hit_b = 1'b0;
        chk("b_time0",      time_b,  0);
        chk("b_over",       state_b, 3);
        chk("b_last_hit",   score_b, 1);
        chk("b_over_end",   end_b,   1);
        chk("b_lives_kept", lives_b, 3);
        start_b = 1'b0;
        step(1);
        start_b = 1'b1;
        chk("b_idle",      state_b, 0);
        chk("b_idle_time", time_b,  2);
        chk("b_idle_score", score_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
